// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the multi-requester UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    WAIT,
    GAP,
    POST
  } sched_state_e;

  localparam logic [15:0] UART_DEFAULT_CLKDIV = 16'd27;

  // Width of an index able to address n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping N-1 -> 0.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);

  logic        found;
  int unsigned cand;

  always_comb begin
    // NOTE: every combinational output gets a default before the loop, so no path leaves a latch.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(ptr_i) + k) % N;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one byte transmitter between NUM_REQ requesters: round-robin grant held for a whole
// message, start/done handshake with guard gap and done-timeout, idle-only baud divisor updates.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT        = 65535,
  parameter logic [15:0] DEFAULT_CLKDIV = UART_DEFAULT_CLKDIV
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_start_o,
  input  logic                 tx_done_i,
  input  logic                 clkdiv_wr_i,
  input  logic [15:0]          clkdiv_i,
  output logic [15:0]          clkdiv_o,
  output logic                 clkdiv_upd_o,
  output logic                 busy_o,
  output logic                 err_timeout_o
);

  localparam int          IDX_W    = idx_width(NUM_REQ);
  localparam logic [16:0] TO_LIM   = 17'(TIMEOUT);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  sched_state_e       state_q;
  logic               lock_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ready_q;
  logic [7:0]         tx_data_q;
  logic               tx_start_q;
  logic [15:0]        cnt_q;
  logic [15:0]        cnt_d;
  logic [16:0]        cnt_nx;
  logic [15:0]        clkdiv_q;
  logic [15:0]        pend_q;
  logic               pend_vld_q;
  logic               upd_q;
  logic               err_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [7:0]         arb_byte;
  logic [7:0]         own_byte;

  rr_arbiter #(.N(NUM_REQ), .W(IDX_W)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign arb_byte = req_data_i[{arb_idx, 3'b000} +: 8];
  assign own_byte = req_data_i[{ptr_q, 3'b000} +: 8];
  assign cnt_nx   = {1'b0, cnt_q} + 17'd1;
  assign cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_nx[15:0];

  // Start, ready and data are registered on entry to LOAD so they are valid for the LOAD cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      lock_q     <= 1'b0;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      ready_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      cnt_q      <= '0;
      clkdiv_q   <= DEFAULT_CLKDIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this block take priority.
      tx_start_q <= 1'b0;
      ready_q    <= '0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pend_vld_q) begin
            clkdiv_q   <= pend_q;
            upd_q      <= 1'b1;
            pend_vld_q <= 1'b0;
          end else if (|req_valid_i) begin
            state_q <= ARB;
          end
        end
        ARB: begin
          if (|req_valid_i) begin
            grant_q    <= arb_gnt;
            ptr_q      <= arb_idx;
            ready_q    <= arb_gnt;
            tx_data_q  <= arb_byte;
            tx_start_q <= 1'b1;
            lock_q     <= ~req_last_i[arb_idx];
            state_q    <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          cnt_q   <= 16'd1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (tx_done_i) begin
            cnt_q   <= '0;
            state_q <= (GAP_CYCLES == 0) ? POST : GAP;
          end else if (TIMEOUT != 0 && cnt_nx >= TO_LIM) begin
            err_q   <= 1'b1;
            lock_q  <= 1'b0;
            grant_q <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) state_q <= POST;
          else                   cnt_q   <= cnt_d;
        end
        POST: begin
          if (!lock_q) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (req_valid_i[ptr_q]) begin
            ready_q    <= grant_q;
            tx_data_q  <= own_byte;
            tx_start_q <= 1'b1;
            lock_q     <= ~req_last_i[ptr_q];
            state_q    <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A write in the apply cycle overrides the pending-clear above and waits for the next IDLE.
      if (clkdiv_wr_i) begin
        pend_q     <= clkdiv_i;
        pend_vld_q <= 1'b1;
      end
    end
  end

  assign req_ready_o   = ready_q;
  assign grant_o       = grant_q;
  assign tx_data_o     = tx_data_q;
  assign tx_start_o    = tx_start_q;
  assign clkdiv_o      = clkdiv_q;
  assign clkdiv_upd_o  = upd_q;
  assign err_timeout_o = err_q;
  assign busy_o        = (state_q != IDLE) || lock_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (4 requesters, 4-cycle guard gap, 100-cycle done-timeout).
module tb_uart_tx_sched;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic [3:0]  grant_o;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_done_i;
  logic        clkdiv_wr_i;
  logic [15:0] clkdiv_i;
  logic [15:0] clkdiv_o;
  logic        clkdiv_upd_o;
  logic        busy_o;
  logic        err_timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_sched #(
    .NUM_REQ(4), .GAP_CYCLES(4), .TIMEOUT(100), .DEFAULT_CLKDIV(16'd27)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_done_i(tx_done_i),
    .clkdiv_wr_i(clkdiv_wr_i), .clkdiv_i(clkdiv_i), .clkdiv_o(clkdiv_o),
    .clkdiv_upd_o(clkdiv_upd_o), .busy_o(busy_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_start(input string tag, input logic [3:0] g, input logic [7:0] d,
                              output int n);
    n = 0;
    while (tx_start_o !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check({tag, " start"}, tx_start_o, 1);
    check({tag, " grant"}, grant_o, g);
    check({tag, " data"}, tx_data_o, d);
    check({tag, " ready"}, req_ready_o, g);
  endtask

  // Called in the start cycle; returns in the cycle after tx_done_i was high.
  task automatic finish_byte(input string tag, input logic [7:0] d, input logic [3:0] g);
    step();
    check({tag, " start pulse"}, tx_start_o, 0);
    check({tag, " ready pulse"}, req_ready_o, 0);
    step();
    step();
    check({tag, " data held"}, tx_data_o, d);
    check({tag, " grant held"}, grant_o, g);
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check({tag, " idle"}, busy_o, 0);
    check({tag, " grant clear"}, grant_o, 0);
  endtask

  initial begin
    int n;
    int starts;
    rst_n_i     = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    tx_done_i   = 1'b0;
    clkdiv_wr_i = 1'b0;
    clkdiv_i    = '0;
    step();
    step();
    check("rst clkdiv", clkdiv_o, 16'd27);
    check("rst grant", grant_o, 0);
    check("rst start", tx_start_o, 0);
    check("rst ready", req_ready_o, 0);
    check("rst busy", busy_o, 0);
    check("rst upd", clkdiv_upd_o, 0);
    check("rst err", err_timeout_o, 0);
    check("rst data", tx_data_o, 0);
    rst_n_i = 1'b1;
    step();

    // 1: single byte from requester 0, start two cycles after valid.
    req_valid_i = 4'b0001;
    req_data_i[7:0] = 8'h55;
    req_last_i = 4'b0001;
    expect_start("t1", 4'b0001, 8'h55, n);
    check("t1 latency", n, 2);
    req_valid_i = '0;
    finish_byte("t1", 8'h55, 4'b0001);
    wait_idle("t1");

    // 2: requesters 1 and 3 contend with single-byte messages.
    req_data_i[15:8]  = 8'h11;
    req_data_i[31:24] = 8'h33;
    req_last_i  = 4'b1010;
    req_valid_i = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] g;
      logic [7:0] d;
      g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      d = (i % 2 == 0) ? 8'h11 : 8'h33;
      expect_start($sformatf("t2 #%0d", i), g, d, n);
      if (i == 3) req_valid_i = '0;
      finish_byte($sformatf("t2 #%0d", i), d, g);
    end
    wait_idle("t2");

    // 3/4: locked 3-byte message from requester 2, requester 0 waiting.
    req_last_i = '0;
    req_data_i[23:16] = 8'hA1;
    req_valid_i = 4'b0100;
    expect_start("t3 b1", 4'b0100, 8'hA1, n);
    req_data_i[23:16] = 8'hA2;
    req_data_i[7:0]   = 8'h5A;
    req_last_i[0]     = 1'b1;
    req_valid_i[0]    = 1'b1;
    finish_byte("t3 b1", 8'hA1, 4'b0100);
    expect_start("t3 b2", 4'b0100, 8'hA2, n);
    check("t4 done-to-start", n, 5);
    req_valid_i[2] = 1'b0;
    finish_byte("t3 b2", 8'hA2, 4'b0100);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) tx_done_i = 1'b1;
      step();
      tx_done_i = 1'b0;
      if (tx_start_o === 1'b1) starts++;
    end
    check("t3 stall starts", starts, 0);
    check("t3 stall grant", grant_o, 4'b0100);
    check("t3 stall busy", busy_o, 1);
    req_data_i[23:16] = 8'hA3;
    req_last_i[2]     = 1'b1;
    req_valid_i[2]    = 1'b1;
    expect_start("t3 b3", 4'b0100, 8'hA3, n);
    check("t3 b3 latency", n, 1);
    req_valid_i[2] = 1'b0;
    req_last_i[2]  = 1'b0;
    finish_byte("t3 b3", 8'hA3, 4'b0100);
    expect_start("t3 req0", 4'b0001, 8'h5A, n);
    check("t3 release latency", n, 7);
    req_valid_i = '0;
    finish_byte("t3 req0", 8'h5A, 4'b0001);
    wait_idle("t3");

    // 5: done never arrives.
    req_data_i[15:8] = 8'h77;
    req_last_i = 4'b0010;
    req_valid_i = 4'b0010;
    expect_start("t5", 4'b0010, 8'h77, n);
    req_valid_i = '0;
    repeat (99) step();
    check("t5 err early", err_timeout_o, 0);
    check("t5 grant early", grant_o, 4'b0010);
    step();
    check("t5 err pulse", err_timeout_o, 1);
    check("t5 grant", grant_o, 0);
    check("t5 busy", busy_o, 0);
    step();
    check("t5 err width", err_timeout_o, 0);

    // 6: divisor write during WAIT is deferred to IDLE.
    req_data_i[31:24] = 8'hC3;
    req_last_i = 4'b1000;
    req_valid_i = 4'b1000;
    expect_start("t6", 4'b1000, 8'hC3, n);
    req_valid_i = '0;
    step();
    clkdiv_wr_i = 1'b1;
    clkdiv_i    = 16'd13;
    step();
    clkdiv_wr_i = 1'b0;
    check("t6 clkdiv deferred", clkdiv_o, 16'd27);
    check("t6 upd deferred", clkdiv_upd_o, 0);
    finish_byte("t6", 8'hC3, 4'b1000);
    n = 0;
    while (clkdiv_upd_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("t6 upd", clkdiv_upd_o, 1);
    check("t6 clkdiv", clkdiv_o, 16'd13);
    check("t6 apply delay", n, 6);
    step();
    check("t6 upd width", clkdiv_upd_o, 0);

    // Write during the apply cycle stays pending and lands one cycle later.
    clkdiv_wr_i = 1'b1;
    clkdiv_i    = 16'd20;
    step();
    clkdiv_i = 16'd40;
    step();
    clkdiv_wr_i = 1'b0;
    check("t6 first apply", clkdiv_o, 16'd20);
    check("t6 first upd", clkdiv_upd_o, 1);
    step();
    check("t6 second apply", clkdiv_o, 16'd40);
    check("t6 second upd", clkdiv_upd_o, 1);
    step();
    check("t6 upd settle", clkdiv_upd_o, 0);

    // Async reset mid-WAIT with a pending write.
    req_data_i[7:0] = 8'h99;
    req_last_i = 4'b0001;
    req_valid_i = 4'b0001;
    expect_start("t6r", 4'b0001, 8'h99, n);
    req_valid_i = '0;
    step();
    clkdiv_wr_i = 1'b1;
    clkdiv_i    = 16'd13;
    step();
    clkdiv_wr_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    check("t6r clkdiv", clkdiv_o, 16'd27);
    check("t6r grant", grant_o, 0);
    check("t6r busy", busy_o, 0);
    step();
    rst_n_i = 1'b1;
    repeat (3) step();
    check("t6r pending dropped", clkdiv_o, 16'd27);
    check("t6r no upd", clkdiv_upd_o, 0);

    // Async reset during the start cycle drops tx_start_o at once.
    req_data_i[15:8] = 8'h42;
    req_last_i = 4'b0010;
    req_valid_i = 4'b0010;
    expect_start("t6s", 4'b0010, 8'h42, n);
    #2 rst_n_i = 1'b0;
    #1;
    check("t6s start drop", tx_start_o, 0);
    check("t6s ready drop", req_ready_o, 0);
    check("t6s data clear", tx_data_o, 0);
    req_valid_i = '0;
    step();
    rst_n_i = 1'b1;
    step();
    check("t6s busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
